onehot_scan_encoder: RTL and testbench
======================================

Name: onehot_scan_encoder

Overview:
Sequential priority encoder, the inverse of the team's N-to-2**N decoder. It accepts a 2**N-bit request vector over a valid/ready handshake and holds it in a pending register. It then emits the N-bit index of each set bit, one index per output handshake, in priority order, and flags the final index. It sits between request-collection logic and any consumer that wants encoded indices, for example a loop that feeds each index back into the decoder.

Parameters:
N, 3, index width; vector width W = 2**N.
LSB_FIRST, 1, 1 = lowest set bit is emitted first; 0 = highest set bit is emitted first.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  in_vec is valid.
in_ready  output  1  block can accept a vector.
in_vec  input  W  request vector, one bit per index.
out_valid  output  1  out_idx is valid.
out_ready  input  1  consumer takes out_idx this cycle.
out_idx  output  N  encoded index of the current highest-priority pending bit.
out_last  output  1  out_idx is the final pending bit of this vector.
zero_err  output  1  one-cycle pulse: an all-zero vector was accepted.
busy  output  1  a vector is being emitted.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE, pend = 0.
  - in_ready = 1 after reset release.
  - out_valid = 0, out_idx = 0, out_last = 0, zero_err = 0, busy = 0.
- States: IDLE, EMIT. Encode them as a typedef in the package.
- IDLE:
  - in_ready = 1, out_valid = 0, busy = 0.
  - Accept on in_valid && in_ready.
  - If in_vec == 0: no load, zero_err = 1 on the next cycle only, stay in IDLE.
  - Otherwise: pend <= in_vec, go to EMIT.
- EMIT:
  - in_ready = 0, busy = 1, out_valid = 1.
  - out_idx = priority index of pend (lowest set bit if LSB_FIRST=1, else highest).
  - out_last = 1 iff pend has exactly one bit set.
  - out_idx and out_last are combinational from registered pend and stay stable while out_ready = 0.
  - On out_valid && out_ready: clear bit out_idx in pend. If out_last, go to IDLE with pend = 0; otherwise stay in EMIT.
- Latency:
  - First index is valid on the cycle after input acceptance.
  - Each subsequent index follows one cycle after each output handshake.
  - Minimum one IDLE cycle between vectors (in_ready is not combinationally tied to out_ready).
- Throughput: one index per cycle when out_ready is held at 1. A vector with k set bits occupies EMIT for k handshakes.
- Boundaries:
  - All W bits set: W indices in order, out_last on the last (W-1 with LSB_FIRST=1, 0 otherwise).
  - in_valid asserted during EMIT: ignored, no accept (in_ready = 0). The source must hold it.
  - out_ready high in IDLE: no effect.
  - rst_n low mid-EMIT: pend is discarded immediately and no further indices are emitted.
  - zero_err never asserts together with out_valid.
- Out-of-range values are not possible: every N-bit out_idx is a legal index.

Decomposition:
- Package onehot_enc_pkg:
  - state typedef enum {IDLE, EMIT}.
  - function popcount_is_one(vector) used for out_last.
- Sub-module prio_enc_comb #(N, LSB_FIRST):
  - Purely combinational, W-bit vector in, N-bit index plus any-set flag out.
  - Instantiated once on pend.
  - Reusable later as a standalone combinational encoder.

Test Plan:
1. N=3, LSB_FIRST=1, in_vec=8'b1010_0100, out_ready=1 -> out_idx 2, 5, 7 on three consecutive cycles; out_last only with 7; busy drops and in_ready rises on the next cycle.
2. Same vector with out_ready toggling 1,0,0,1,1 -> out_idx holds at 5 through the stall cycles; no index is lost or duplicated; exactly 3 handshakes.
3. in_vec=8'h00 accepted -> zero_err high for exactly one cycle, out_valid stays 0, in_ready stays 1.
4. LSB_FIRST=0, in_vec=8'b1010_0100 -> out_idx 7, 5, 2; out_last with 2. Also in_vec=8'h80 -> single idx 7 with out_last=1.
5. in_vec=8'hFF, then rst_n pulsed low after the third handshake -> all outputs return to reset values asynchronously. After release, in_ready=1 and a new vector 8'h01 yields idx 0 with out_last=1.
6. Exhaustive: all 256 vectors with random out_ready backpressure -> the emitted index set equals the set bits in priority order. Scoreboard decodes each index with the existing decoder and ORs the results, which must equal in_vec.

Source files
------------

// File: rtl/onehot_scan_encoder_pkg.sv
// Shared types and helpers for the one-hot scan encoder.
// Vectors up to 256 bits (N <= 8) are supported by the helpers.
package onehot_enc_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  localparam int MAX_W = 256;

  // True when exactly one bit is set.
  function automatic logic popcount_is_one(
    input logic [MAX_W-1:0] v
  );
    return (v != '0) &&
           ((v & (v - MAX_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/onehot_scan_encoder_if.sv
// Request-in / index-out handshake bundle.
// master drives requests and takes indices; slave is the encoder.
interface onehot_scan_encoder_if #(
  parameter int N = 3
) ();
  localparam int W = 1 << N;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_vec;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_idx;
  logic         out_last;

  modport master (
    output in_valid,
    output in_vec,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_idx,
    input  out_last
  );

  modport slave (
    input  in_valid,
    input  in_vec,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_idx,
    output out_last
  );

endinterface

// File: rtl/onehot_scan_encoder_prio_enc_comb.sv
// Combinational priority encoder: W-bit vector to N-bit index.
// idx is 0 when no bit is set; any flags a non-empty vector.
module prio_enc_comb #(
  parameter int N         = 3,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic [(1<<N)-1:0] vec,
  output logic [N-1:0]      idx,
  output logic              any
);
  localparam int W = 1 << N;

  // Later hits overwrite earlier ones, so scan toward the winner.
  always_comb begin
    idx = '0;
    any = |vec;
    if (LSB_FIRST) begin
      for (int i = W - 1; i >= 0; i--) begin
        if (vec[i]) idx = N'(i);
      end
    end else begin
      for (int i = 0; i < W; i++) begin
        if (vec[i]) idx = N'(i);
      end
    end
  end

endmodule

// File: rtl/onehot_scan_encoder.sv
// Sequential priority encoder: takes a request vector and emits
// the index of every set bit, one per output handshake.
module onehot_scan_encoder
  import onehot_enc_pkg::*;
#(
  parameter int N         = 3,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  onehot_scan_encoder_if.slave bus,
  output logic                zero_err,
  output logic                busy
);
  localparam int W = 1 << N;

  state_t       state;
  state_t       state_nxt;
  logic [W-1:0] pend;
  logic [W-1:0] pend_nxt;
  logic         zero_nxt;
  logic [N-1:0] idx;
  logic         any;
  logic         last;
  logic         emit;

  prio_enc_comb #(
    .N        (N),
    .LSB_FIRST(LSB_FIRST)
  ) u_prio (
    .vec(pend),
    .idx(idx),
    .any(any)
  );

  assign emit = (state == EMIT);
  assign last = popcount_is_one(MAX_W'(pend));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pend     <= '0;
      zero_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      pend     <= pend_nxt;
      zero_err <= zero_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    pend_nxt      = pend;
    zero_nxt      = 1'b0;
    bus.in_ready  = !emit;
    bus.out_valid = emit && any;
    bus.out_idx   = idx;
    bus.out_last  = emit && last;
    busy          = emit;
    unique case (state)
      IDLE: begin
        if (bus.in_valid) begin
          if (bus.in_vec == '0) begin
            zero_nxt = 1'b1;
          end else begin
            pend_nxt  = bus.in_vec;
            state_nxt = EMIT;
          end
        end
      end
      EMIT: begin
        if (bus.out_ready) begin
          pend_nxt[idx] = 1'b0;
          if (last || !any) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_onehot_scan_encoder.sv
// Bench for onehot_scan_encoder: LSB-first and MSB-first copies
// share stimulus and are checked against a queue-based model.
module tb_onehot_scan_encoder;
  localparam int N = 3;
  localparam int W = 1 << N;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid  = 1'b0;
  logic [W-1:0] in_vec    = '0;
  logic         out_ready = 1'b0;
  int           rdy_mode  = 0;

  onehot_scan_encoder_if #(.N(N)) ifa ();
  onehot_scan_encoder_if #(.N(N)) ifb ();

  assign ifa.in_valid  = in_valid;
  assign ifa.in_vec    = in_vec;
  assign ifa.out_ready = out_ready;
  assign ifb.in_valid  = in_valid;
  assign ifb.in_vec    = in_vec;
  assign ifb.out_ready = out_ready;

  logic zea, busya, zeb, busyb;

  onehot_scan_encoder #(.N(N), .LSB_FIRST(1'b1)) dut_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (ifa),
    .zero_err(zea),
    .busy    (busya)
  );

  onehot_scan_encoder #(.N(N), .LSB_FIRST(1'b0)) dut_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (ifb),
    .zero_err(zeb),
    .busy    (busyb)
  );

  int checks   = 0;
  int failures = 0;

  // Model: pending indices in emission order for each copy.
  int           qa[$];
  int           qb[$];
  logic         zexp    = 1'b0;
  logic [W-1:0] cur_vec = '0;

  // Scoreboard state.
  logic [W-1:0] acc_a = '0;
  logic [W-1:0] acc_b = '0;
  int           gota[$];
  int           gotb[$];
  int           hs_a   = 0;
  int           zcount = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic chk_list(input string nm,
                          input int g[$],
                          input int e[$]);
    chk({nm, "_len"}, g.size(), e.size());
    for (int i = 0; i < g.size() && i < e.size(); i++)
      chk({nm, "_item"}, g[i], e[i]);
  endtask

  function automatic logic [W-1:0] decode(input logic [N-1:0] i);
    logic [W-1:0] one;
    one = W'(1);
    return one << i;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qa.delete();
      qb.delete();
      zexp  = 1'b0;
      acc_a = '0;
      acc_b = '0;
    end else begin
      zexp = 1'b0;
      if (qa.size() == 0) begin
        if (in_valid) begin
          if (in_vec == '0) begin
            zexp = 1'b1;
          end else begin
            cur_vec = in_vec;
            for (int i = 0; i < W; i++) begin
              if (in_vec[i]) begin
                qa.push_back(i);
                qb.push_front(i);
              end
            end
          end
        end
      end else if (out_ready) begin
        void'(qa.pop_front());
        void'(qb.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    chk("a_out_valid", ifa.out_valid, qa.size() != 0);
    chk("a_in_ready", ifa.in_ready, qa.size() == 0);
    chk("a_busy", busya, qa.size() != 0);
    chk("a_zero_err", zea, zexp);
    chk("b_out_valid", ifb.out_valid, qb.size() != 0);
    chk("b_in_ready", ifb.in_ready, qb.size() == 0);
    chk("b_busy", busyb, qb.size() != 0);
    chk("b_zero_err", zeb, zexp);
    if (qa.size() != 0) begin
      chk("a_out_idx", ifa.out_idx, qa[0]);
      chk("a_out_last", ifa.out_last, qa.size() == 1);
    end else begin
      chk("a_out_last_idle", ifa.out_last, 0);
    end
    if (qb.size() != 0) begin
      chk("b_out_idx", ifb.out_idx, qb[0]);
      chk("b_out_last", ifb.out_last, qb.size() == 1);
    end else begin
      chk("b_out_last_idle", ifb.out_last, 0);
    end
    if (zea) zcount++;
    if (rst_n && ifa.out_valid && out_ready) begin
      acc_a = acc_a | decode(ifa.out_idx);
      gota.push_back(int'(ifa.out_idx));
      hs_a++;
      if (ifa.out_last) begin
        chk("a_decode_or", acc_a, cur_vec);
        acc_a = '0;
      end
    end
    if (rst_n && ifb.out_valid && out_ready) begin
      acc_b = acc_b | decode(ifb.out_idx);
      gotb.push_back(int'(ifb.out_idx));
      if (ifb.out_last) begin
        chk("b_decode_or", acc_b, cur_vec);
        acc_b = '0;
      end
    end
  end

  always @(posedge clk) begin
    #2;
    if (rdy_mode == 1) out_ready = 1'($urandom_range(0, 1));
    else if (rdy_mode == 0) out_ready = 1'b1;
  end

  // Called at posedge+2; returns at posedge+2 after acceptance.
  task automatic send(input logic [W-1:0] v);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_vec   = v;
    do begin
      @(posedge clk);
      n++;
    end while (!ifa.in_ready && n < 200);
    chk("send_accepted", ifa.in_ready, 1);
    #2;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((qa.size() != 0 || busya) && n < budget) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("idle_reached", qa.size() == 0 && !busya, 1);
  endtask

  initial begin
    int e[$];
    int n;
    rdy_mode = 0;
    @(posedge clk);
    #1;
    chk("rst_a_valid", ifa.out_valid, 0);
    chk("rst_a_idx", ifa.out_idx, 0);
    chk("rst_a_last", ifa.out_last, 0);
    chk("rst_a_busy", busya, 0);
    chk("rst_a_zero", zea, 0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    chk("rel_in_ready", ifa.in_ready, 1);

    // Test 1: A4 at full throughput.
    gota.delete(); gotb.delete();
    send(8'hA4);
    wait_idle(50);
    e = {2, 5, 7}; chk_list("t1_lsb", gota, e);
    e = {7, 5, 2}; chk_list("t1_msb", gotb, e);

    // Test 2: stall pattern 1,0,0,1,1.
    rdy_mode = 2; out_ready = 1'b0;
    @(posedge clk); #2;
    gota.delete(); gotb.delete(); hs_a = 0;
    send(8'hA4);
    e = {1, 0, 0, 1, 1};
    foreach (e[i]) begin
      out_ready = e[i][0];
      @(posedge clk);
      #2;
    end
    out_ready = 1'b0;
    chk("t2_handshakes", hs_a, 3);
    e = {2, 5, 7}; chk_list("t2_lsb", gota, e);
    e = {7, 5, 2}; chk_list("t2_msb", gotb, e);

    // Test 3: zero vector.
    rdy_mode = 0;
    @(posedge clk); #2;
    zcount = 0;
    send(8'h00);
    repeat (3) @(posedge clk);
    #2;
    chk("t3_zero_pulses", zcount, 1);

    // Test 4: single top bit.
    gota.delete(); gotb.delete();
    send(8'h80);
    wait_idle(20);
    e = {7}; chk_list("t4_lsb", gota, e);
    e = {7}; chk_list("t4_msb", gotb, e);

    // Test 5: async reset mid-emit.
    hs_a = 0;
    send(8'hFF);
    n = 0;
    while (hs_a < 3 && n < 50) begin
      @(posedge clk);
      n++;
    end
    chk("t5_hs_before_rst", hs_a, 3);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t5_a_valid", ifa.out_valid, 0);
    chk("t5_a_busy", busya, 0);
    chk("t5_a_idx", ifa.out_idx, 0);
    chk("t5_a_last", ifa.out_last, 0);
    chk("t5_b_valid", ifb.out_valid, 0);
    chk("t5_b_busy", busyb, 0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    chk("t5_in_ready", ifa.in_ready, 1);
    gota.delete(); gotb.delete();
    send(8'h01);
    wait_idle(20);
    e = {0}; chk_list("t5_lsb", gota, e);
    e = {0}; chk_list("t5_msb", gotb, e);

    // Test 6: every vector, random backpressure.
    rdy_mode = 1;
    for (int v = 0; v < 256; v++) send(W'(v));
    wait_idle(200);
    rdy_mode = 0;
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
